// File: rtl/mips_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle
// Brief    : Multi-cycle 32-bit MIPS subset core (ADD/SUB/AND/OR/SLT, ADDI,
//            LW/SW, BEQ/BNE, J, HALT) sequenced by an explicit FSM, with one
//            shared request/ready memory port that tolerates any wait state.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1,
    parameter int unsigned MEM_TIMEOUT     = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err,
    input  logic [4:0]  dbg_sel,
    output logic [31:0] dbg_data
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_MEM    = 3'd4;
    localparam logic [2:0] c_ST_WB     = 3'd5;
    localparam logic [2:0] c_ST_HALT   = 3'd6;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_HALT  = 6'h3F;

    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    localparam bit          c_TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [31:0] c_TO_LAST = 32'(MEM_TIMEOUT) - 32'd1;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [31:0] r_addr;
    logic [31:0] r_wbdata;
    logic [4:0]  r_dst;
    logic [31:0] r_retired;
    logic [31:0] r_tcnt;
    logic        r_illegal;
    logic        r_bus_err;
    logic [31:0] r_regs [32];

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic        w_fn_ok;
    logic        w_taken;
    logic        w_xfer;
    logic        w_timeout;
    logic [31:0] w_alu;
    logic        w_retire;
    logic        w_set_ill;
    logic        w_set_bus;
    logic        w_pc_load;
    logic [31:0] w_pc_tgt;
    logic        w_bad;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];

    assign w_fn_ok = (w_funct == c_FN_ADD) || (w_funct == c_FN_SUB) ||
                     (w_funct == c_FN_AND) || (w_funct == c_FN_OR)  ||
                     (w_funct == c_FN_SLT);
    assign w_taken = (w_op == c_OP_BEQ) ? (r_a == r_b) : (r_a != r_b);

    // Memory port is a pure function of state so addr/we/wdata never move mid-request
    assign mem_req   = (r_state == c_ST_FETCH) || (r_state == c_ST_MEM);
    assign mem_we    = (r_state == c_ST_MEM) && (w_op == c_OP_SW);
    assign mem_addr  = (r_state == c_ST_MEM) ? r_addr : r_pc;
    assign mem_wdata = mem_we ? r_b : 32'd0;

    assign w_xfer    = mem_req && mem_ready;
    assign w_timeout = c_TO_EN && mem_req && !mem_ready && (r_tcnt == c_TO_LAST);

    assign pc       = r_pc;
    assign retired  = r_retired;
    assign halted   = (r_state == c_ST_HALT);
    assign illegal  = r_illegal;
    assign bus_err  = r_bus_err;
    assign dbg_data = (dbg_sel == 5'd0) ? 32'd0 : r_regs[dbg_sel];

    // ALU: immediate add by default (ADDI and LW/SW address), R-type by funct
    always_comb begin
        w_alu = r_a + r_imm;
        if (w_op == c_OP_RTYPE) begin
            case (w_funct)
                c_FN_SUB: w_alu = r_a - r_b;
                c_FN_AND: w_alu = r_a & r_b;
                c_FN_OR:  w_alu = r_a | r_b;
                c_FN_SLT: w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
                default:  w_alu = r_a + r_b;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, retire and halt-cause decisions
    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_set_ill   = 1'b0;
        w_set_bus   = 1'b0;
        w_pc_load   = 1'b0;
        w_pc_tgt    = r_pc;
        w_bad       = 1'b0;
        case (r_state)
            c_ST_IDLE: w_state_nxt = c_ST_FETCH;
            c_ST_FETCH: begin
                if (w_timeout) begin
                    w_state_nxt = c_ST_HALT;
                    w_set_bus   = 1'b1;
                end else if (w_xfer) begin
                    w_state_nxt = c_ST_DECODE;
                end
            end
            c_ST_DECODE: w_state_nxt = c_ST_EXEC;
            c_ST_EXEC: begin
                case (w_op)
                    c_OP_RTYPE: begin
                        if (w_fn_ok) begin
                            w_state_nxt = c_ST_WB;
                        end else begin
                            w_bad = 1'b1;
                        end
                    end
                    c_OP_ADDI: w_state_nxt = c_ST_WB;
                    c_OP_LW, c_OP_SW: w_state_nxt = c_ST_MEM;
                    c_OP_BEQ, c_OP_BNE: begin
                        w_retire    = 1'b1;
                        w_state_nxt = c_ST_FETCH;
                        if (w_taken) begin
                            w_pc_load = 1'b1;
                            w_pc_tgt  = r_pc + (r_imm << 2);
                        end
                    end
                    c_OP_J: begin
                        w_retire    = 1'b1;
                        w_state_nxt = c_ST_FETCH;
                        w_pc_load   = 1'b1;
                        w_pc_tgt    = {r_pc[31:28], r_ir[25:0], 2'b00};
                    end
                    c_OP_HALT: begin
                        w_retire    = 1'b1;
                        w_state_nxt = c_ST_HALT;
                    end
                    default: w_bad = 1'b1;
                endcase
                if (w_bad) begin
                    if (HALT_ON_ILLEGAL) begin
                        w_state_nxt = c_ST_HALT;
                        w_set_ill   = 1'b1;
                    end else begin
                        w_retire    = 1'b1;
                        w_state_nxt = c_ST_FETCH;
                    end
                end
            end
            c_ST_MEM: begin
                if (w_timeout) begin
                    w_state_nxt = c_ST_HALT;
                    w_set_bus   = 1'b1;
                end else if (w_xfer) begin
                    if (w_op == c_OP_SW) begin
                        w_retire    = 1'b1;
                        w_state_nxt = c_ST_FETCH;
                    end else begin
                        w_state_nxt = c_ST_WB;
                    end
                end
            end
            c_ST_WB: begin
                w_retire    = 1'b1;
                w_state_nxt = c_ST_FETCH;
            end
            c_ST_HALT: w_state_nxt = c_ST_HALT;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Datapath registers: IR/PC, operand latches, results, counters, halt causes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_imm     <= 32'd0;
            r_addr    <= 32'd0;
            r_wbdata  <= 32'd0;
            r_dst     <= 5'd0;
            r_retired <= 32'd0;
            r_tcnt    <= 32'd0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_tcnt <= 32'd0;
            end else if (mem_req) begin
                r_tcnt <= r_tcnt + 32'd1;
            end
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
            if (w_set_ill) begin
                r_illegal <= 1'b1;
            end
            if (w_set_bus) begin
                r_bus_err <= 1'b1;
            end
            case (r_state)
                c_ST_FETCH: begin
                    if (w_xfer) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + 32'd4;
                    end
                end
                c_ST_DECODE: begin
                    r_a   <= r_regs[w_rs];
                    r_b   <= r_regs[w_rt];
                    r_imm <= {{16{r_ir[15]}}, r_ir[15:0]};
                end
                c_ST_EXEC: begin
                    r_wbdata <= w_alu;
                    r_addr   <= w_alu;
                    r_dst    <= (w_op == c_OP_RTYPE) ? w_rd : w_rt;
                    if (w_pc_load) begin
                        r_pc <= w_pc_tgt;
                    end
                end
                c_ST_MEM: begin
                    if (w_xfer) begin
                        r_wbdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file: write-back only, register 0 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if ((r_state == c_ST_WB) && (r_dst != 5'd0)) begin
            r_regs[r_dst] <= r_wbdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle
// Brief    : Self-checking bench; an instruction-level model predicts every
//            memory transaction, the retired count and the final register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle;

    localparam logic [5:0] c_OP_J    = 6'h02;
    localparam logic [5:0] c_OP_BEQ  = 6'h04;
    localparam logic [5:0] c_OP_BNE  = 6'h05;
    localparam logic [5:0] c_OP_ADDI = 6'h08;
    localparam logic [5:0] c_OP_LW   = 6'h23;
    localparam logic [5:0] c_OP_SW   = 6'h2B;
    localparam logic [5:0] c_OP_HALT = 6'h3F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_cmd, sel, mem_ready;
    logic [31:0] mem_rdata;
    logic [4:0]  dbg_sel;

    logic        req_a, we_a, halted_a, ill_a, berr_a, reset_a, ready_a;
    logic [31:0] addr_a, wdata_a, pc_a, ret_a, dbg_a;
    logic        req_b, we_b, halted_b, ill_b, berr_b, reset_b, ready_b;
    logic [31:0] addr_b, wdata_b, pc_b, ret_b, dbg_b;

    // The unselected core is held in reset and sees no ready
    assign reset_a = rst_cmd || sel;
    assign reset_b = rst_cmd || !sel;
    assign ready_a = mem_ready && !sel;
    assign ready_b = mem_ready && sel;

    logic        mem_req, mem_we, halted, illegal, bus_err;
    logic [31:0] mem_addr, mem_wdata, pc, retired, dbg_data;
    assign mem_req   = sel ? req_b    : req_a;
    assign mem_we    = sel ? we_b     : we_a;
    assign mem_addr  = sel ? addr_b   : addr_a;
    assign mem_wdata = sel ? wdata_b  : wdata_a;
    assign pc        = sel ? pc_b     : pc_a;
    assign retired   = sel ? ret_b    : ret_a;
    assign halted    = sel ? halted_b : halted_a;
    assign illegal   = sel ? ill_b    : ill_a;
    assign bus_err   = sel ? berr_b   : berr_a;
    assign dbg_data  = sel ? dbg_b    : dbg_a;

    mips_multicycle #(.RESET_PC(32'h0), .HALT_ON_ILLEGAL(1'b1), .MEM_TIMEOUT(0)) dut_a (
        .clk(clk), .reset(reset_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .mem_rdata(mem_rdata), .mem_ready(ready_a), .pc(pc_a),
        .retired(ret_a), .halted(halted_a), .illegal(ill_a), .bus_err(berr_a),
        .dbg_sel(dbg_sel), .dbg_data(dbg_a));

    mips_multicycle #(.RESET_PC(32'h0), .HALT_ON_ILLEGAL(1'b0), .MEM_TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .mem_rdata(mem_rdata), .mem_ready(ready_b), .pc(pc_b),
        .retired(ret_b), .halted(halted_b), .illegal(ill_b), .bus_err(berr_b),
        .dbg_sel(dbg_sel), .dbg_data(dbg_b));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bench memory (what the core sees) and the model's private copy
    logic [31:0] mem  [1024];
    logic [31:0] mmem [1024];

    // Instruction-level model state
    logic [31:0] m_pc, m_ret;
    logic [31:0] m_regs [32];
    bit          m_halted, m_ill, m_hoi;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] ret;
        logic        fetch;
    } txn_t;
    txn_t expq[$];

    // Executes one whole instruction and queues the transactions it must cause
    function automatic void model_step();
        logic [31:0] inst, npc, a, b, imm, ea;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        bit          bad;
        txn_t        t;
        inst = mmem[m_pc[11:2]];
        t.addr = m_pc; t.we = 1'b0; t.wdata = 32'd0; t.ret = m_ret; t.fetch = 1'b1;
        expq.push_back(t);
        npc = m_pc + 32'd4;
        op = inst[31:26]; fn = inst[5:0];
        rs = inst[25:21]; rt = inst[20:16]; rd = inst[15:11];
        imm = {{16{inst[15]}}, inst[15:0]};
        a = m_regs[rs]; b = m_regs[rt];
        ea = a + imm;
        bad = 1'b0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: m_regs[rd] = a + b;
                    6'h22: m_regs[rd] = a - b;
                    6'h24: m_regs[rd] = a & b;
                    6'h25: m_regs[rd] = a | b;
                    6'h2A: m_regs[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: bad = 1'b1;
                endcase
            end
            c_OP_ADDI: m_regs[rt] = ea;
            c_OP_LW: begin
                t.addr = ea; t.we = 1'b0; t.wdata = 32'd0; t.fetch = 1'b0;
                expq.push_back(t);
                m_regs[rt] = mmem[ea[11:2]];
            end
            c_OP_SW: begin
                t.addr = ea; t.we = 1'b1; t.wdata = b; t.fetch = 1'b0;
                expq.push_back(t);
                mmem[ea[11:2]] = b;
            end
            c_OP_BEQ: if (a == b) npc = npc + (imm * 4);
            c_OP_BNE: if (a != b) npc = npc + (imm * 4);
            c_OP_J:   npc = {npc[31:28], inst[25:0], 2'b00};
            c_OP_HALT: m_halted = 1'b1;
            default: bad = 1'b1;
        endcase
        m_regs[0] = 32'd0;
        if (bad && m_hoi) begin
            m_halted = 1'b1;
            m_ill = 1'b1;
        end else begin
            m_ret = m_ret + 32'd1;
            m_pc = npc;
        end
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic void clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        for (int i = 128; i < 160; i++) mem[i] = $urandom();
    endfunction

    // Random program of n instructions with forward-only control flow, then HALT
    function automatic void gen_random(input int n);
        logic [5:0] fns [5];
        logic [4:0] rs, rt, rd;
        int k;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        clear_mem();
        for (int i = 0; i < n; i++) begin
            k  = $urandom_range(0, 99);
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            if (k < 40)      mem[i] = enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]);
            else if (k < 55) mem[i] = enc_i(c_OP_ADDI, rs, rt, 16'($urandom()));
            else if (k < 65) mem[i] = enc_i(c_OP_LW, 5'd0, rt, 16'(32'h200 + 4 * $urandom_range(0, 31)));
            else if (k < 75) mem[i] = enc_i(c_OP_SW, 5'd0, rt, 16'(32'h200 + 4 * $urandom_range(0, 31)));
            else if (k < 85) mem[i] = enc_i(($urandom_range(0, 1) != 0) ? c_OP_BEQ : c_OP_BNE, rs, rt,
                                            16'($urandom_range(0, n - 1 - i)));
            else if (k < 91) mem[i] = {c_OP_J, 26'($urandom_range(i + 1, n))};
            else if (k < 93) mem[i] = ($urandom_range(0, 1) != 0) ? 32'hF800_0000 : enc_r(rs, rt, rd, 6'h00);
            else             mem[i] = enc_i(c_OP_ADDI, 5'd0, rd, 16'($urandom_range(0, 15)));
        end
        mem[n] = {c_OP_HALT, 26'd0};
    endfunction

    // Responder and compare process state
    bit          active = 1'b0, hold0 = 1'b0, in_txn = 1'b0;
    int          maxwait, fixedwait, waits;
    int          cyc, first_req_cyc, halt_cyc, req_cycles;
    logic [31:0] last_fetch;
    txn_t        cur;

    // Serve the memory port and check every requesting cycle against the model
    always @(negedge clk) begin
        if (active) begin
            cyc++;
            if (halted && halt_cyc < 0) halt_cyc = cyc;
            if (mem_req) begin
                req_cycles++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                if (!in_txn) begin
                    if (expq.size() == 0 && !m_halted) model_step();
                    if (expq.size() == 0) begin
                        chk("unexpected_req", 32'(mem_req), 32'd0);
                    end else begin
                        cur = expq.pop_front();
                        in_txn = 1'b1;
                        waits = (fixedwait >= 0) ? fixedwait : int'($urandom_range(0, maxwait));
                        if (cur.fetch) begin
                            chk("retired_at_fetch", retired, cur.ret);
                            chk("pc_at_fetch", pc, cur.addr);
                            last_fetch = cur.addr;
                        end
                    end
                end
                if (in_txn) begin
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_we", 32'(mem_we), 32'(cur.we));
                    if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                end
                if (in_txn && !hold0 && waits == 0) begin
                    mem_ready = 1'b1;
                    if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                    else        mem_rdata = mem[mem_addr[11:2]];
                    in_txn = 1'b0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom();
                    if (waits > 0) waits--;
                end
            end else begin
                if (in_txn && !hold0) chk("req_held", 32'(mem_req), 32'd1);
                in_txn = 1'b0;
                mem_ready = ($urandom_range(0, 1) != 0);
                mem_rdata = $urandom();
            end
        end
    end

    task automatic start_run(input bit s, input int mw, input int fw, input bit h0);
        @(negedge clk);
        active = 1'b0;
        rst_cmd = 1'b1;
        sel = s;
        m_hoi = !s;
        maxwait = mw; fixedwait = fw; hold0 = h0;
        for (int i = 0; i < 1024; i++) mmem[i] = mem[i];
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = 32'd0; m_ret = 32'd0; m_halted = 1'b0; m_ill = 1'b0;
        expq.delete();
        in_txn = 1'b0; waits = 0;
        cyc = 0; first_req_cyc = -1; halt_cyc = -1; req_cycles = 0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_cmd = 1'b0;
        active = 1'b1;
    endtask

    task automatic wait_halt(input int limit);
        int c;
        c = 0;
        while (!halted && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
        #1;
        active = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic final_checks(input string tag);
        int mism;
        chk({tag, "_halted"}, 32'(halted), 32'd1);
        chk({tag, "_illegal"}, 32'(illegal), 32'(m_ill));
        chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
        chk({tag, "_retired"}, retired, m_ret);
        chk({tag, "_txn_left"}, 32'(expq.size()), 32'd0);
        chk({tag, "_req_in_halt"}, 32'(mem_req), 32'd0);
        for (int r = 0; r < 32; r++) begin
            dbg_sel = 5'(r);
            #1;
            chk($sformatf("%s_r%0d", tag, r), dbg_data, m_regs[r]);
        end
        mism = 0;
        for (int i = 128; i < 160; i++) if (mem[i] !== mmem[i]) mism++;
        chk({tag, "_dmem"}, 32'(mism), 32'd0);
    endtask

    task automatic read_reg(input int r, output logic [31:0] v);
        dbg_sel = 5'(r);
        #1;
        v = dbg_data;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int c;
        rst_cmd = 1'b1; sel = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0; dbg_sel = 5'd5;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_dbg", dbg_data, 32'd0);

        // ALU program, ready tied high
        clear_mem();
        mem[0] = enc_i(c_OP_ADDI, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(c_OP_ADDI, 5'd0, 5'd2, 16'hFFFD);
        mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        mem[3] = enc_r(5'd1, 5'd2, 5'd4, 6'h22);
        mem[4] = enc_r(5'd2, 5'd1, 5'd5, 6'h2A);
        mem[5] = {c_OP_HALT, 26'd0};
        start_run(1'b0, 0, 0, 1'b0);
        wait_halt(200);
        final_checks("alu");
        chk("alu_cycles", 32'(halt_cyc - first_req_cyc), 32'd23);
        chk("alu_retired_lit", retired, 32'd6);
        read_reg(3, v); chk("alu_r3_lit", v, 32'd2);
        read_reg(4, v); chk("alu_r4_lit", v, 32'd8);
        read_reg(5, v); chk("alu_r5_lit", v, 32'd1);

        // Load/store, two wait states on every access
        clear_mem();
        mem[0] = enc_i(c_OP_ADDI, 5'd0, 5'd1, 16'h0123);
        mem[1] = enc_i(c_OP_SW, 5'd0, 5'd1, 16'h0040);
        mem[2] = enc_i(c_OP_LW, 5'd0, 5'd6, 16'h0040);
        mem[3] = {c_OP_HALT, 26'd0};
        start_run(1'b0, 0, 2, 1'b0);
        wait_halt(200);
        final_checks("ldst");
        read_reg(6, v); chk("ldst_r6_lit", v, 32'h123);

        // Branch loop counting r1 to 4, skipped store to r1, write to r0
        clear_mem();
        mem[0] = enc_i(c_OP_ADDI, 5'd0, 5'd1, 16'd0);
        mem[1] = enc_i(c_OP_ADDI, 5'd0, 5'd2, 16'd4);
        mem[2] = enc_i(c_OP_ADDI, 5'd1, 5'd1, 16'd1);
        mem[3] = enc_i(c_OP_BNE, 5'd1, 5'd2, 16'hFFFE);
        mem[4] = enc_i(c_OP_BEQ, 5'd0, 5'd0, 16'd1);
        mem[5] = enc_i(c_OP_ADDI, 5'd0, 5'd1, 16'd99);
        mem[6] = enc_i(c_OP_ADDI, 5'd0, 5'd0, 16'd7);
        mem[7] = {c_OP_HALT, 26'd0};
        start_run(1'b0, 2, -1, 1'b0);
        wait_halt(500);
        final_checks("br");
        read_reg(1, v); chk("br_r1_lit", v, 32'd4);
        read_reg(0, v); chk("br_r0_lit", v, 32'd0);

        // Jump to word 0x10
        clear_mem();
        mem[0]  = {c_OP_J, 26'h10};
        mem[16] = {c_OP_HALT, 26'd0};
        start_run(1'b0, 0, 0, 1'b0);
        wait_halt(100);
        final_checks("jmp");
        chk("jmp_target_lit", last_fetch, 32'h40);

        // Illegal opcode 0x3E on both halt policies
        for (int s = 0; s < 2; s++) begin
            clear_mem();
            mem[0] = enc_i(c_OP_ADDI, 5'd0, 5'd1, 16'd1);
            mem[1] = 32'hF800_0000;
            mem[2] = enc_i(c_OP_ADDI, 5'd0, 5'd2, 16'd2);
            mem[3] = {c_OP_HALT, 26'd0};
            start_run(1'(s), 1, -1, 1'b0);
            wait_halt(200);
            final_checks(s == 0 ? "ill_halt" : "ill_nop");
            read_reg(2, v);
            chk("ill_retired_lit", retired, (s == 0) ? 32'd1 : 32'd4);
            chk("ill_flag_lit", 32'(illegal), (s == 0) ? 32'd1 : 32'd0);
            chk("ill_r2_lit", v, (s == 0) ? 32'd0 : 32'd2);
        end

        // Random programs on both cores with random wait states
        for (int k = 0; k < 8; k++) begin
            gen_random(40);
            start_run(1'(k % 2), 3, -1, 1'b0);
            wait_halt(3000);
            final_checks($sformatf("rnd%0d", k));
        end

        // Bus timeout after 8 unanswered request cycles
        clear_mem();
        mem[0] = enc_i(c_OP_ADDI, 5'd0, 5'd1, 16'd1);
        start_run(1'b1, 0, 0, 1'b1);
        wait_halt(100);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_illegal", 32'(illegal), 32'd0);
        chk("to_retired", retired, 32'd0);
        chk("to_req_cycles", 32'(req_cycles), 32'd8);

        // Reset while a load is stalled: no write-back, clean refetch
        clear_mem();
        mem[0]  = enc_i(c_OP_LW, 5'd0, 5'd6, 16'h0040);
        mem[16] = 32'hDEAD_BEEF;
        @(negedge clk);
        active = 1'b0; sel = 1'b0; rst_cmd = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        rst_cmd = 1'b0;
        c = 0;
        while (!mem_req && c < 20) begin @(negedge clk); c++; end
        chk("rs_fetch_req", 32'(mem_req), 32'd1);
        chk("rs_fetch_addr", mem_addr, 32'h0);
        mem_ready = 1'b1; mem_rdata = mem[0];
        @(negedge clk);
        mem_ready = 1'b0;
        c = 0;
        while (!mem_req && c < 20) begin @(negedge clk); c++; end
        chk("rs_lw_addr", mem_addr, 32'h40);
        @(negedge clk);
        @(negedge clk);
        chk("rs_lw_stalled", 32'(mem_req), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; rst_cmd = 1'b1;
        @(negedge clk);
        chk("rs_req_after_reset", 32'(mem_req), 32'd0);
        rst_cmd = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("rs_refetch_req", 32'(mem_req), 32'd1);
        chk("rs_refetch_addr", mem_addr, 32'h0);
        chk("rs_retired", retired, 32'd0);
        read_reg(6, v); chk("rs_r6", v, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
